// File: rtl/rancnetwork_output_axis.sv
// AXI-Stream master returning output-core spikes of the RANC grid to the host.
// Spikes are queued in a circular FIFO and every tick appends an end-of-tick
// marker word (tlast=1), so the host sees exactly one frame per tick.
module rancnetwork_output_axis #(
  parameter int NUM_OUTPUTS            = 256,
  parameter int OUTPUT_BUFFER_DEPTH    = 512,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  tick,
  input  logic [$clog2(NUM_OUTPUTS)-1:0]        packet_out,
  input  logic                                  packet_out_valid,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  output_overflow_error,
  output logic [$clog2(OUTPUT_BUFFER_DEPTH):0]  buffer_level
);

  localparam int IW = $clog2(NUM_OUTPUTS);
  localparam int AW = $clog2(OUTPUT_BUFFER_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int EW = DW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(OUTPUT_BUFFER_DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} ostate_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] mem_q [OUTPUT_BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [LW-1:0] count_q, count_d, free;

  // Frame counters
  logic [13:0] tick_idx_q, tick_idx_d;
  logic [15:0] spk_cnt_q, spk_cnt_d, cnt_inc;
  logic        drop_q, drop_d, drop_now;
  logic        ovf_q, ovf_d;

  // Output stage
  ostate_t       state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          spike_ok, marker_ok, spike_rej, fifo_nonempty, rd_en;
  logic          we0, we1;
  logic [1:0]    n_wr;
  logic [EW-1:0] spike_word, marker_word, w0, w1, head;

  // Admission control, word formation and write-port steering
  always_comb begin
    free          = DEPTH_L - count_q;
    wr_ptr_p1     = wr_ptr_q + AW'(1);
    fifo_nonempty = (count_q != '0);
    head          = mem_q[rd_ptr_q];

    // A spike must leave one slot free so the next marker always fits.
    spike_ok  = packet_out_valid && (free >= LW'(2));
    spike_rej = packet_out_valid && !spike_ok;
    marker_ok = tick && (free >= LW'(1));

    // A spike arriving with the tick belongs to the frame being closed.
    cnt_inc  = (spike_ok && (spk_cnt_q != '1)) ? spk_cnt_q + 16'd1 : spk_cnt_q;
    drop_now = drop_q | spike_rej;

    spike_word               = '0;
    spike_word[IW-1:0]       = packet_out;
    marker_word              = {1'b1, 1'b1, drop_now, tick_idx_q, cnt_inc};

    // Port 0 takes the spike if any, else the marker; port 1 only carries
    // the marker when both land in the same cycle.
    we0  = spike_ok || marker_ok;
    we1  = spike_ok && marker_ok;
    w0   = spike_ok ? spike_word : marker_word;
    w1   = marker_word;
    n_wr = {1'b0, spike_ok} + {1'b0, marker_ok};

    rd_en = fifo_nonempty && ((state_q == S_EMPTY) || m00_axis_tready);

    wr_ptr_d = wr_ptr_q + AW'(n_wr);
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + LW'(n_wr) - LW'(rd_en);

    if (tick) begin
      tick_idx_d = tick_idx_q + 14'd1;
      spk_cnt_d  = '0;
      drop_d     = 1'b0;
    end else begin
      tick_idx_d = tick_idx_q;
      spk_cnt_d  = cnt_inc;
      drop_d     = drop_now;
    end
    ovf_d = ovf_q | spike_rej | (tick && !marker_ok);
  end

  // FIFO array write ports (contents need no reset; pointers gate validity)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we0) mem_q[wr_ptr_q]  <= w0;
      if (we1) mem_q[wr_ptr_p1] <= w1;
    end
  end

  // Pointer, level, counter and error-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tick_idx_q <= '0;
      spk_cnt_q  <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tick_idx_q <= tick_idx_d;
      spk_cnt_q  <= spk_cnt_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output stage next-state: load head when empty or on a completed transfer
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (state_q)
      S_EMPTY: begin
        if (rd_en) begin
          out_data_d = head[DW-1:0];
          out_last_d = head[DW];
          state_d    = S_FULL;
        end
      end
      S_FULL: begin
        if (rd_en) begin
          out_data_d = head[DW-1:0];
          out_last_d = head[DW];
        end else if (m00_axis_tready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign m00_axis_tvalid       = (state_q == S_FULL);
  assign m00_axis_tdata        = out_data_q;
  assign m00_axis_tlast        = out_last_q;
  assign m00_axis_tstrb        = '1;
  assign output_overflow_error = ovf_q;
  assign buffer_level          = count_q;

endmodule

// File: tb/tb_rancnetwork_output_axis.sv
// Scoreboard bench for rancnetwork_output_axis with a 4-entry buffer.
module tb_rancnetwork_output_axis;

  localparam int DEPTH = 4;
  localparam int NOUT  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [7:0]  packet_out;
  logic        packet_out_valid;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        ovf;
  logic [2:0]  level;

  rancnetwork_output_axis #(
    .NUM_OUTPUTS(NOUT),
    .OUTPUT_BUFFER_DEPTH(DEPTH),
    .C_M00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .packet_out(packet_out),
    .packet_out_valid(packet_out_valid),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast),
    .m00_axis_tready(tready),
    .output_overflow_error(ovf),
    .buffer_level(level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected words {tlast, tdata} in host arrival order
  logic [32:0] exp_q[$];

  // Reference model: words accepted but not yet handed to the host
  int          occ    = 0;
  bit          m_outv = 1'b0;
  logic [13:0] m_tidx = '0;
  logic [15:0] m_cnt  = '0;
  bit          m_drop = 1'b0;
  bit          m_ovf  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: frame rules applied to an occupancy count per clock
  always @(posedge clk) begin : model
    int  fifo_n;
    int  free;
    int  wr;
    bit  xfer;
    if (rst) begin
      exp_q.delete();
      occ    = 0;
      m_outv = 1'b0;
      m_tidx = '0;
      m_cnt  = '0;
      m_drop = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      fifo_n = occ - (m_outv ? 1 : 0);
      free   = DEPTH - fifo_n;
      xfer   = m_outv && (tready === 1'b1);
      wr     = 0;
      if (packet_out_valid) begin
        if (free >= 2) begin
          exp_q.push_back({1'b0, 24'd0, packet_out});
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          wr++;
        end else begin
          m_drop = 1'b1;
          m_ovf  = 1'b1;
        end
      end
      if (tick) begin
        if (free >= 1) begin
          exp_q.push_back({1'b1, 1'b1, m_drop, m_tidx, m_cnt});
          wr++;
        end else begin
          m_ovf = 1'b1;
        end
        m_tidx = m_tidx + 14'd1;
        m_cnt  = '0;
        m_drop = 1'b0;
      end
      occ = occ + wr - (xfer ? 1 : 0);
      if (!m_outv || xfer) m_outv = (fifo_n > 0);
    end
  end

  // Monitor: compare every handshake and the status outputs mid-cycle
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rst === 1'b0) begin
      check("tvalid", 64'(tvalid), 64'(m_outv));
      check("buffer_level", 64'(level), 64'(occ - (m_outv ? 1 : 0)));
      check("overflow", 64'(ovf), 64'(m_ovf));
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL word actual=0x%0h required=none at %0t", {tlast, tdata}, $time);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'({tlast, tdata}), 64'(e));
        end
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] p, input bit t);
    packet_out_valid = v;
    packet_out       = p;
    tick             = t;
    @(posedge clk);
    #1;
    packet_out_valid = 1'b0;
    tick             = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic drain();
    tready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_outv); i++) idle(1);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; tick = 1'b0; packet_out = '0; packet_out_valid = 1'b0; tready = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tstrb", 64'(tstrb), 64'hF);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    @(posedge clk); #1;

    // Basic frame with two-cycle latency
    tready = 1'b1;
    step(1'b1, 8'd3, 1'b0);
    check("latency_edge_n", 64'(tvalid), 64'd0);
    step(1'b1, 8'd7, 1'b0);
    check("latency_edge_n1", 64'(tvalid), 64'd1);
    check("first_word", 64'(tdata), 64'h3);
    step(1'b1, 8'd200, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    drain();

    // Empty ticks
    do_reset();
    tready = 1'b1;
    repeat (3) step(1'b0, 8'd0, 1'b1);
    drain();

    // Spike coinciding with tick
    do_reset();
    step(1'b1, 8'd5, 1'b1);
    step(1'b1, 8'd9, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    drain();

    // Backpressure
    do_reset();
    tready = 1'b0;
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    idle(1);
    check("bp_level", 64'(level), 64'd3);
    held = tdata;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("bp_tdata_stable", 64'(tdata), 64'(held));
      check("bp_tvalid_held", 64'(tvalid), 64'd1);
    end
    drain();

    // Overflow: marker parked in output register, then a burst of spikes
    do_reset();
    tready = 1'b0;
    step(1'b0, 8'd0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_level_full", 64'(level), 64'(DEPTH));
    drain();

    // Reset in the middle of a stalled handshake
    do_reset();
    tready = 1'b0;
    step(1'b1, 8'd7, 1'b0);
    idle(2);
    check("mid_tvalid_before", 64'(tvalid), 64'd1);
    do_reset();
    check("mid_tvalid_after", 64'(tvalid), 64'd0);
    check("mid_level_after", 64'(level), 64'd0);
    tready = 1'b1;
    step(1'b0, 8'd0, 1'b1);
    drain();

    // Randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tready = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 9) < 6), 8'($urandom_range(0, NOUT - 1)),
           ($urandom_range(0, 7) == 0));
    end
    drain();

    // Tick every cycle long enough to wrap the tick index
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 16400; i++)
      step(($urandom_range(0, 3) == 0), 8'($urandom_range(0, NOUT - 1)), 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
